// File: rtl/truth_table_sequencer.sv
// Exhaustive 3-input truth-table checker: steps {A,B,C} through 000..111, lets the
// unit under test settle, samples its F output and records per-vector mismatches.
module truth_table_sequencer #(
  parameter logic [7:0]  EXPECTED = 8'b1110_1000,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_settle_cnt;
  logic [2:0] r_abc;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_count;
  logic [7:0] r_fail_mask;

  state_t     w_state;
  logic [2:0] w_idx;
  logic [3:0] w_settle_cnt;
  logic [2:0] w_abc;
  logic       w_busy;
  logic       w_done;
  logic       w_pass;
  logic [3:0] w_fail_count;
  logic [7:0] w_fail_mask;
  logic       w_mismatch;

  assign w_mismatch = (f_in != EXPECTED[r_idx]);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    w_state      = r_state;
    w_idx        = r_idx;
    w_settle_cnt = r_settle_cnt;
    w_fail_count = r_fail_count;
    w_fail_mask  = r_fail_mask;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state      = S_SETTLE;
          w_idx        = 3'd0;
          w_settle_cnt = 4'd0;
          w_fail_count = 4'd0;
          w_fail_mask  = 8'h00;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state = S_SAMPLE;
        end else begin
          w_settle_cnt = r_settle_cnt + 4'd1;
        end
      end
      S_SAMPLE: begin
        // At most one increment per vector, so the count cannot pass 8.
        if (w_mismatch) begin
          w_fail_mask[r_idx] = 1'b1;
          w_fail_count       = r_fail_count + 4'd1;
        end
        if (r_idx == 3'd7) begin
          w_state = S_DONE;
        end else begin
          w_idx        = r_idx + 3'd1;
          w_settle_cnt = 4'd0;
          w_state      = S_SETTLE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered and then registered,
    // so they line up with the state and never see start/f_in combinationally.
    w_busy = (w_state == S_SETTLE) || (w_state == S_SAMPLE);
    w_done = (w_state == S_DONE);
    w_pass = w_done && (w_fail_count == 4'd0);
    w_abc  = w_busy ? w_idx : 3'b000;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_settle_cnt <= 4'd0;
      r_abc        <= 3'b000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= 4'd0;
      r_fail_mask  <= 8'h00;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_settle_cnt <= w_settle_cnt;
      r_abc        <= w_abc;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_pass       <= w_pass;
      r_fail_count <= w_fail_count;
      r_fail_mask  <= w_fail_mask;
    end
  end

  assign {a_out, b_out, c_out} = r_abc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_count = r_fail_count;
  assign fail_mask  = r_fail_mask;

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter EXPECTED, default 8'b1110_1000, giving the expected F per input index; bit i = expected F for {A,B,C} = i.
REQ-002 SHALL have parameter SETTLE, default 2, giving the number of cycles each vector is driven before sampling; legal range 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  request one full 8-vector run; sampled on rising edge.
REQ-006 SHALL have port f_in  input  1  F output of the downstream combinational Boolean unit under test.
REQ-007 SHALL have ports a_out, b_out, c_out  output  1 each  registered A, B, C drive to the unit under test.
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port done  output  1  high from run completion until the next accepted start or reset.
REQ-010 SHALL have port pass  output  1  valid while done=1; 1 iff no mismatches occurred.
REQ-011 SHALL have port fail_count  output  4  number of mismatching vectors in the last run, 0..8.
REQ-012 SHALL have port fail_mask  output  8  bit i set iff vector i mismatched.

Function
REQ-013 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 SHALL, in IDLE, drive a_out/b_out/c_out = 0 and busy = 0.
REQ-015 SHALL, in IDLE or DONE with start=1, clear idx, settle counter, fail_mask, fail_count and done, then enter SETTLE.
REQ-016 SHALL, in SETTLE and SAMPLE, drive {a_out,b_out,c_out} = idx[2:0] (a_out MSB), held constant.
REQ-017 SHALL remain in SETTLE for exactly SETTLE cycles, then enter SAMPLE.
REQ-018 SHALL, in SAMPLE (1 cycle), compare f_in with EXPECTED[idx]; on mismatch set fail_mask[idx] and increment fail_count.
REQ-019 SHALL, after SAMPLE, enter DONE if idx = 7; otherwise increment idx, clear the settle counter and re-enter SETTLE.
REQ-020 SHALL apply vectors strictly in order 000, 001, ..., 111, each driven for SETTLE+1 cycles.
REQ-021 SHALL assert busy in SETTLE and SAMPLE only.
REQ-022 SHALL, in DONE, assert done, drive pass = (fail_count == 0), hold fail_mask and fail_count, and drive a_out/b_out/c_out = 0.
REQ-023 SHALL ignore start while busy = 1 (no restart, no clearing).
REQ-024 SHALL enter DONE exactly 8*(SETTLE+1) rising edges after the edge that accepted start (24 edges at SETTLE = 2).
REQ-025 SHALL make idx 3 bits and never let it wrap during a run; the idx = 7 check takes precedence over increment.
REQ-026 SHALL saturate fail_count at 8 by construction; it SHALL NOT exceed 8.
REQ-027 SHALL register all outputs; no output SHALL depend combinationally on start or f_in.

Reset
REQ-028 SHALL, on the rising edge where rst_n = 0, enter IDLE and clear idx, the settle counter, a_out, b_out, c_out, busy, done, pass, fail_count and fail_mask to 0.
REQ-029 SHALL give reset priority over start and over any state transition, including mid-run.
REQ-030 SHALL need one edge with rst_n = 1 and start = 1 to begin a run after reset.

Verification
REQ-031 SHALL cover: f_in from an ideal model of EXPECTED, start pulse -> done at edge 24, pass = 1, fail_count = 0, fail_mask = 8'h00.
REQ-032 SHALL cover: f_in stuck at 0, default EXPECTED -> pass = 0, fail_count = 4, fail_mask = 8'hE8.
REQ-033 SHALL cover: abc monitor over one run -> 000..111 in order, each held 3 cycles, then 000 in DONE; vector 001 expects F = 0.
REQ-034 SHALL cover: rst_n low for 1 cycle at edge 10 of a run -> all outputs 0 next cycle, state IDLE, no done.
REQ-035 SHALL cover: start re-pulsed while busy -> ignored, done still at edge 24; start in DONE -> results cleared, new run begins.
REQ-036 SHALL cover: SETTLE = 1 with ideal f_in -> done at edge 16, pass = 1.
